// File: rtl/xnor_cmp_pkg.sv
// Shared encodings for the bit-serial XNOR compare controller.
// The state values and requester indices are used by the controller and its arbiter.
package xnor_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/exnorGate.sv
// Single-bit XNOR comparison cell: c is high when a and b agree.
module exnorGate (
    input  logic a,
    input  logic b,
    output logic c
);

    assign c = ~(a ^ b);

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: on a tie, the requester that was not granted last wins.
module rr_arb2
    import xnor_cmp_pkg::*;
(
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_last_grant,
    output logic o_winner,
    output logic o_valid
);

    always_comb begin
        o_valid  = i_req0 | i_req1;
        o_winner = REQ0;
        if (i_req0 && i_req1) begin
            o_winner = ~i_last_grant;
        end else if (i_req1) begin
            o_winner = REQ1;
        end
    end

endmodule

// File: rtl/xnor_serial_cmp_ctrl.sv
// Shares one exnorGate cell between two requesters, comparing latched operands LSB-first
// one bit per cycle and returning equality plus the count of agreeing bit positions.
module xnor_serial_cmp_ctrl
    import xnor_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             busy,
    output logic             done0,
    output logic             done1,
    output logic             eq,
    output logic [CNT_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    state_t             r_state;
    logic [WIDTH-1:0]   r_shA;
    logic [WIDTH-1:0]   r_shB;
    logic [CNT_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_accCnt;
    logic               r_accEq;
    logic               r_lastGrant;
    logic               r_gnt0;
    logic               r_gnt1;
    logic               r_busy;
    logic               r_done0;
    logic               r_done1;
    logic               r_eq;
    logic [CNT_W-1:0]   r_matchCnt;

    logic               w_winner;
    logic               w_valid;
    logic               w_c;
    logic [CNT_W-1:0]   w_cntNext;
    logic               w_eqNext;

    rr_arb2 u_arb (
        .i_req0       (req0),
        .i_req1       (req1),
        .i_last_grant (r_lastGrant),
        .o_winner     (w_winner),
        .o_valid      (w_valid)
    );

    exnorGate u_cell (
        .a (r_shA[0]),
        .b (r_shB[0]),
        .c (w_c)
    );

    assign w_cntNext = r_accCnt + CNT_W'(w_c);
    assign w_eqNext  = r_accEq & w_c;

    // last_grant doubles as the identity of the requester currently being served
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_shA       <= '0;
            r_shB       <= '0;
            r_idx       <= '0;
            r_accCnt    <= '0;
            r_accEq     <= 1'b0;
            r_lastGrant <= REQ1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_busy      <= 1'b0;
            r_done0     <= 1'b0;
            r_done1     <= 1'b0;
            r_eq        <= 1'b0;
            r_matchCnt  <= '0;
        end else begin
            r_gnt0  <= 1'b0;
            r_gnt1  <= 1'b0;
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_shA       <= (w_winner == REQ1) ? a1 : a0;
                        r_shB       <= (w_winner == REQ1) ? b1 : b0;
                        r_accCnt    <= '0;
                        r_accEq     <= 1'b1;
                        r_idx       <= '0;
                        r_lastGrant <= w_winner;
                        r_gnt0      <= (w_winner == REQ0);
                        r_gnt1      <= (w_winner == REQ1);
                        r_busy      <= 1'b1;
                        r_state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    r_accCnt <= w_cntNext;
                    r_accEq  <= w_eqNext;
                    r_shA    <= r_shA >> 1;
                    r_shB    <= r_shB >> 1;
                    r_idx    <= r_idx + CNT_W'(1);
                    if (r_idx == LAST_IDX) begin
                        r_eq       <= w_eqNext;
                        r_matchCnt <= w_cntNext;
                        r_done0    <= (r_lastGrant == REQ0);
                        r_done1    <= (r_lastGrant == REQ1);
                        r_state    <= DONE;
                    end
                end
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign gnt0      = r_gnt0;
    assign gnt1      = r_gnt1;
    assign busy      = r_busy;
    assign done0     = r_done0;
    assign done1     = r_done1;
    assign eq        = r_eq;
    assign match_cnt = r_matchCnt;

endmodule
